alu16_sequencer: RTL and testbench

- Sequences the 8-bit CPU ALU over two cycles to execute 16-bit operations: ADD HL,rr; ADD SP,e8 (also used for LD HL,SP+e8); INC rr; DEC rr.
- Sits between the CPU control unit and the ALU, and owns the ALU inputs while busy.
- The control unit issues one request over a valid/ready handshake and receives a 16-bit result plus CHNZ flags over a second valid/ready handshake.

---
 rtl/alu16_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu16_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu16_sequencer.sv
// Two-cycle 16-bit operation sequencer over the CPU's 8-bit ALU.
// Handles ADD HL,rr / ADD SP,e8 / INC rr / DEC rr with valid/ready request and response.
module alu16_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  output logic [3:0]  alu_flag_in,
  output logic [2:0]  alu_bit_index,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flag_out
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD16, OP_ADD_SP_E8, OP_INC16, OP_DEC16} op_e;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_ADC    = 5'b00001;
  localparam logic [4:0] ALU_SUB    = 5'b00010;
  localparam logic [4:0] ALU_SBC    = 5'b00011;
  localparam logic [4:0] ALU_COPY_A = 5'b11000;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic        c_lo_q, c_lo_d;
  logic        h_lo_q, h_lo_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  rflags_q, rflags_d;

  // ALU Z/N outputs are never consumed; ADD16 Z comes from the captured flags.
  logic unused_alu_zn;
  assign unused_alu_zn = ^alu_flag_out[3:2];

  assign alu_bit_index = '0;
  assign resp_result   = result_q;
  assign resp_flags    = rflags_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    flags_d     = flags_q;
    res_lo_d    = res_lo_q;
    c_lo_d      = c_lo_q;
    h_lo_d      = h_lo_q;
    result_d    = result_q;
    rflags_d    = rflags_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALU_COPY_A;
    alu_flag_in = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          flags_d = req_flags;
          state_d = S_LO;
        end
      end
      S_LO: begin
        alu_a  = a_q[7:0];
        alu_b  = (op_q == OP_INC16 || op_q == OP_DEC16) ? 8'h01 : b_q[7:0];
        alu_op = (op_q == OP_DEC16) ? ALU_SUB : ALU_ADD;
        res_lo_d = alu_out;
        c_lo_d   = alu_flag_out[0];
        h_lo_d   = alu_flag_out[1];
        state_d  = S_HI;
      end
      S_HI: begin
        alu_a       = a_q[15:8];
        alu_op      = (op_q == OP_DEC16) ? ALU_SBC : ALU_ADC;
        alu_flag_in = {3'b000, c_lo_q};
        case (op_q)
          OP_ADD16:     alu_b = b_q[15:8];
          OP_ADD_SP_E8: alu_b = {8{b_q[7]}};
          default:      alu_b = 8'h00;
        endcase
        result_d = {alu_out, res_lo_q};
        case (op_q)
          OP_ADD16:     rflags_d = {flags_q[3], 1'b0, alu_flag_out[1], alu_flag_out[0]};
          OP_ADD_SP_E8: rflags_d = {2'b00, h_lo_q, c_lo_q};
          default:      rflags_d = flags_q;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD16;
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      res_lo_q <= '0;
      c_lo_q   <= 1'b0;
      h_lo_q   <= 1'b0;
      result_q <= '0;
      rflags_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      flags_q  <= flags_d;
      res_lo_q <= res_lo_d;
      c_lo_q   <= c_lo_d;
      h_lo_q   <= h_lo_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Bench for alu16_sequencer: behavioural 8-bit ALU stub, 16-bit reference model,
// directed corner cases followed by randomized operations.
module tb_alu16_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_result;
  logic [3:0]  resp_flags;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flag_in;
  logic [2:0]  alu_bit_index;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flag_out;

  int n_total = 0;
  int n_pass  = 0;

  alu16_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
    .alu_bit_index(alu_bit_index), .alu_out(alu_out), .alu_flag_out(alu_flag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU stub: flags {Z,N,H,C}, C = carry for add, borrow for subtract
  logic [8:0] full;
  logic [4:0] half;
  logic       cin;
  always_comb begin
    cin  = (alu_op == 5'b00001 || alu_op == 5'b00011) ? alu_flag_in[0] : 1'b0;
    full = '0;
    half = '0;
    alu_out      = alu_a;
    alu_flag_out = alu_flag_in;
    case (alu_op)
      5'b00000, 5'b00001: begin
        full = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, cin};
        half = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, cin};
        alu_out      = full[7:0];
        alu_flag_out = {full[7:0] == 8'h00, 1'b0, half[4], full[8]};
      end
      5'b00010, 5'b00011: begin
        full = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, cin};
        half = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'b0, cin};
        alu_out      = full[7:0];
        alu_flag_out = {full[7:0] == 8'h00, 1'b1, half[4], full[8]};
      end
      default: ;
    endcase
  end

  // 16-bit reference: results and flags derived from whole-word arithmetic
  task automatic ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f, output logic [15:0] res, output logic [3:0] fl);
    int unsigned s, h, c;
    case (op)
      2'd0: begin
        s   = int'(a) + int'(b);
        h   = ((int'(a) & 32'hFFF) + (int'(b) & 32'hFFF)) >> 12;
        res = s[15:0];
        fl  = {f[3], 1'b0, h[0], s[16]};
      end
      2'd1: begin
        s   = int'(a) + int'({{8{b[7]}}, b[7:0]});
        h   = ((int'(a) & 32'hF) + (int'(b) & 32'hF)) >> 4;
        c   = ((int'(a) & 32'hFF) + (int'(b) & 32'hFF)) >> 8;
        res = s[15:0];
        fl  = {2'b00, h[0], c[0]};
      end
      2'd2: begin res = a + 16'd1; fl = f; end
      default: begin res = a - 16'd1; fl = f; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, input int unsigned hold);
    logic [15:0] er;
    logic [3:0]  ef;
    logic [7:0]  eb_hi;
    ref_model(op, a, b, f, er, ef);
    eb_hi = (op == 2'd0) ? b[15:8] : (op == 2'd1) ? {8{b[7]}} : 8'h00;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_flags = f;
    resp_ready = (hold == 0);
    tick();
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_flags = 4'($urandom);
    check("lo_req_ready", req_ready, 0);
    check("lo_resp_valid", resp_valid, 0);
    check("lo_alu_op", alu_op, (op == 2'd3) ? 5'b00010 : 5'b00000);
    check("lo_alu_a", alu_a, a[7:0]);
    check("lo_alu_flag_in", alu_flag_in, 0);
    tick();
    check("hi_resp_valid", resp_valid, 0);
    check("hi_alu_op", alu_op, (op == 2'd3) ? 5'b00011 : 5'b00001);
    check("hi_alu_a", alu_a, a[15:8]);
    check("hi_alu_b", alu_b, eb_hi);
    tick();
    check("done_resp_valid", resp_valid, 1);
    check("done_req_ready", req_ready, 0);
    check("done_result", resp_result, er);
    check("done_flags", resp_flags, ef);
    for (int unsigned i = 0; i < hold; i++) begin
      req_valid = (i == 0);
      tick();
      req_valid = 1'b0;
      check("hold_resp_valid", resp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_result", resp_result, er);
      check("hold_flags", resp_flags, ef);
    end
    resp_ready = 1'b1;
    tick();
    check("post_resp_valid", resp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_alu_op", alu_op, 5'b11000);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_flags = '0; resp_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_result", resp_result, 0);
    check("rst_flags", resp_flags, 0);
    check("rst_alu_op", alu_op, 5'b11000);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_flag_in", alu_flag_in, 0);
    check("rst_bit_index", alu_bit_index, 0);
    reset = 1'b0;
    tick();

    run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000, 0);
    check("add16_h_result", resp_result, 16'h1000);
    check("add16_h_flags", resp_flags, 4'b1010);
    run_op(2'd0, 16'h8000, 16'h8000, 4'b0000, 0);
    check("add16_c_flags", resp_flags, 4'b0001);
    run_op(2'd1, 16'hFFF8, 16'h0008, 4'b1111, 0);
    check("addsp_pos_flags", resp_flags, 4'b0011);
    run_op(2'd1, 16'h0005, 16'h00FE, 4'b0000, 0);
    check("addsp_neg_result", resp_result, 16'h0003);
    run_op(2'd3, 16'h0000, 16'h1234, 4'b1111, 0);
    check("dec_wrap_result", resp_result, 16'hFFFF);
    run_op(2'd2, 16'hFFFF, 16'h0000, 4'b0100, 0);
    check("inc_wrap_result", resp_result, 16'h0000);
    check("inc_wrap_flags", resp_flags, 4'b0100);
    run_op(2'd0, 16'h1234, 16'h4321, 4'b0110, 5);

    // reset while the high byte is in flight must drop the operation
    req_valid = 1'b1; req_op = 2'd0; req_a = 16'hABCD; req_b = 16'h1111; req_flags = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    check("midrst_in_hi", alu_op, 5'b00001);
    reset = 1'b1;
    tick();
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_alu_op", alu_op, 5'b11000);
    check("midrst_result", resp_result, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst_no_resp", resp_valid, 0);
    end

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 4'($urandom),
             $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
